// File: rtl/run_extractor_pkg.sv
// Shared vision-pipeline definitions: column width, run word layout and the
// marker codes used between the run extractor, run FIFO manager and blob stage.
package run_extractor_pkg;

    localparam int COL_W_DEF   = 11;
    localparam int MIN_RUN_DEF = 2;
    localparam int GAP_TOL_DEF = 1;

    // Marker codes carried in the flag bit of a run word downstream
    localparam logic LINE_MARK  = 1'b0;
    localparam logic FRAME_MARK = 1'b1;

    typedef struct packed {
        logic                 flag;
        logic [COL_W_DEF-1:0] start_col;
        logic [COL_W_DEF-1:0] end_col;
    } run_word_t;

    function automatic run_word_t pack_run(input logic                 flag,
                                           input logic [COL_W_DEF-1:0] start_col,
                                           input logic [COL_W_DEF-1:0] end_col);
        run_word_t w;
        w.flag      = flag;
        w.start_col = start_col;
        w.end_col   = end_col;
        return w;
    endfunction

endpackage

// File: rtl/run_extractor_if.sv
// Pixel-in / run-out bundle between the pixel classifier, run_extractor and run_fifo_manager.
interface run_extractor_if import run_extractor_pkg::*; #(
    parameter int COL_W = COL_W_DEF
) ();

    logic             px_valid;
    logic             px_match;
    logic             px_eol;
    logic             px_eof;
    logic [COL_W-1:0] run_start;
    logic [COL_W-1:0] run_end;
    logic             new_run;
    logic             end_line;
    logic             end_frame;
    logic             col_ovf;

    modport master (
        output px_valid, px_match, px_eol, px_eof,
        input  run_start, run_end, new_run, end_line, end_frame, col_ovf
    );

    modport slave (
        input  px_valid, px_match, px_eol, px_eof,
        output run_start, run_end, new_run, end_line, end_frame, col_ovf
    );

endinterface

// File: rtl/run_extractor_gap_tracker.sv
// Counts consecutive non-matching pixels inside an open run and decides when
// the next miss exceeds the bridging tolerance and must close the run.
module run_gap_tracker #(
    parameter int GAP_TOL = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic step,
    input  logic open,
    input  logic match,
    input  logic clr,
    output logic close_on_miss
);

    localparam int GW = (GAP_TOL < 1) ? 1 : $clog2(GAP_TOL + 1);
    localparam logic [GW-1:0] TOL = GW'(GAP_TOL);

    logic [GW-1:0] gap_cnt_q;
    logic [GW-1:0] gap_cnt_d;

    // With GAP_TOL=0 the count stays 0 and every miss in a run closes it
    assign close_on_miss = open && !match && (gap_cnt_q == TOL);

    always_comb begin
        gap_cnt_d = gap_cnt_q;
        if (step) begin
            if (!open || match || clr || close_on_miss) begin
                gap_cnt_d = '0;
            end else begin
                gap_cnt_d = gap_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gap_cnt_q <= '0;
        end else begin
            gap_cnt_q <= gap_cnt_d;
        end
    end

endmodule

// File: rtl/run_extractor.sv
// Turns the per-pixel colour-match stream into (start, end) horizontal runs,
// bridging short gaps, dropping short runs and flagging line/frame ends.
module run_extractor import run_extractor_pkg::*; #(
    parameter int COL_W   = COL_W_DEF,
    parameter int MIN_RUN = MIN_RUN_DEF,
    parameter int GAP_TOL = GAP_TOL_DEF
) (
    input  logic            clk,
    input  logic            rst,
    run_extractor_if.slave  bus
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    localparam logic [COL_W-1:0] COL_MAX = '1;
    localparam logic [COL_W:0]   MIN_LEN = (COL_W+1)'(MIN_RUN);

    logic [1:0]       state_q, state_d;
    logic [COL_W-1:0] col_q, col_d;
    logic             col_full_q, col_full_d;
    logic [COL_W-1:0] start_q, start_d;
    logic [COL_W-1:0] last_q, last_d;
    logic [COL_W-1:0] run_start_q, run_start_d;
    logic [COL_W-1:0] run_end_q, run_end_d;
    logic             new_run_q, new_run_d;
    logic             end_line_q, end_line_d;
    logic             end_frame_q, end_frame_d;
    logic             col_ovf_q, col_ovf_d;

    logic px_last;
    logic run_open;
    logic gap_close;
    logic close_now;

    function automatic logic [COL_W-1:0] col_next(input logic [COL_W-1:0] c);
        return (c == COL_MAX) ? c : c + 1'b1;
    endfunction

    function automatic logic long_enough(input logic [COL_W-1:0] s,
                                         input logic [COL_W-1:0] e);
        logic [COL_W:0] len;
        len = {1'b0, e} - {1'b0, s} + 1'b1;
        return len >= MIN_LEN;
    endfunction

    assign px_last  = bus.px_eol | bus.px_eof;
    assign run_open = (state_q != ST_IDLE);

    run_gap_tracker #(
        .GAP_TOL (GAP_TOL)
    ) u_gap (
        .clk           (clk),
        .rst           (rst),
        .step          (bus.px_valid),
        .open          (run_open),
        .match         (bus.px_match),
        .clr           (px_last),
        .close_on_miss (gap_close)
    );

    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        col_full_d  = col_full_q;
        start_d     = start_q;
        last_d      = last_q;
        run_start_d = run_start_q;
        run_end_d   = run_end_q;
        new_run_d   = 1'b0;
        end_line_d  = 1'b0;
        end_frame_d = 1'b0;
        col_ovf_d   = end_frame_q ? 1'b0 : col_ovf_q;
        close_now   = 1'b0;

        if (bus.px_valid) begin
            // A pixel arriving after the counter already passed its top column overflows the line
            if (col_full_q) begin
                col_ovf_d = 1'b1;
            end

            case (state_q)
                ST_IDLE: begin
                    if (bus.px_match) begin
                        start_d = col_q;
                        last_d  = col_q;
                        state_d = ST_RUN;
                    end
                end
                ST_RUN, ST_GAP: begin
                    if (bus.px_match) begin
                        last_d  = col_q;
                        state_d = ST_RUN;
                    end else if (gap_close) begin
                        close_now = 1'b1;
                        state_d   = ST_IDLE;
                    end else begin
                        state_d = ST_GAP;
                    end
                end
                default: state_d = ST_IDLE;
            endcase

            // Line end closes whatever is still open after this pixel's match is taken
            if (px_last && (state_d != ST_IDLE)) begin
                close_now = 1'b1;
                state_d   = ST_IDLE;
            end

            if (close_now && long_enough(start_d, last_d)) begin
                new_run_d   = 1'b1;
                run_start_d = start_d;
                run_end_d   = last_d;
            end

            end_line_d  = px_last;
            end_frame_d = bus.px_eof;

            if (px_last) begin
                col_d      = '0;
                col_full_d = 1'b0;
            end else begin
                col_d      = col_next(col_q);
                col_full_d = col_full_q | (col_q == COL_MAX);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            col_q       <= '0;
            col_full_q  <= 1'b0;
            start_q     <= '0;
            last_q      <= '0;
            run_start_q <= '0;
            run_end_q   <= '0;
            new_run_q   <= 1'b0;
            end_line_q  <= 1'b0;
            end_frame_q <= 1'b0;
            col_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            col_full_q  <= col_full_d;
            start_q     <= start_d;
            last_q      <= last_d;
            run_start_q <= run_start_d;
            run_end_q   <= run_end_d;
            new_run_q   <= new_run_d;
            end_line_q  <= end_line_d;
            end_frame_q <= end_frame_d;
            col_ovf_q   <= col_ovf_d;
        end
    end

    assign bus.run_start = run_start_q;
    assign bus.run_end   = run_end_q;
    assign bus.new_run   = new_run_q;
    assign bus.end_line  = end_line_q;
    assign bus.end_frame = end_frame_q;
    assign bus.col_ovf   = col_ovf_q;

endmodule
